// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: the hex glyph table,
// the segment bit layout and the nibble-to-glyph lookup.
package seg7_pkg;

  // Active-high gfedcba patterns. Entry 0 is the rightmost element of the concatenation.
  localparam logic [15:0][6:0] HEX_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam int         DP_BIT  = 7;

  function automatic logic [6:0] seg7_hex(input logic [3:0] nibble);
    return HEX_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational glyph generator: one nibble plus its decimal point in, an
// active-high {dp,g..a} pattern out, forced fully dark on request.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       dark,
  output logic [7:0] seg
);

  always_comb begin
    // NOTE: assign a default before any branch so every path drives seg and no latch is inferred.
    seg = SEG_OFF;
    if (!dark) begin
      seg[6:0]    = seg7_hex(nibble);
      seg[DP_BIT] = dp;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment scanner with double-buffered contents,
// guard interval, blanking, leading-zero suppression and blinking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int DIV          = 16,
  parameter int GUARD        = 1,
  parameter int BLINK_FRAMES = 64,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic [N_DIGITS-1:0]   blink_mask,
  input  logic                  lz_blank,
  input  logic                  load,
  output logic                  upd_done,
  output logic [N_DIGITS-1:0]   AN,
  output logic [7:0]            SEG
);

  localparam int PRES_W  = $clog2(DIV);
  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef struct packed {
    logic [4*N_DIGITS-1:0] data;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   blank;
    logic [N_DIGITS-1:0]   blink;
    logic                  lz;
  } disp_t;

  logic [PRES_W-1:0]  pres, pres_next;
  logic [IDX_W-1:0]   idx, idx_next;
  logic [FRAME_W-1:0] frame_cnt, frame_next;
  logic               phase, phase_next;
  logic               pres_last, idx_last, fb;

  disp_t load_val, pending, shadow;
  logic  pend_v;

  assign pres_last = (pres == PRES_W'(DIV - 1));
  assign idx_last  = (idx == IDX_W'(N_DIGITS - 1));
  assign fb        = pres_last && idx_last;

  // ---------------------------------------------------------------- scan timing
  always_comb begin
    pres_next  = pres + 1'b1;
    idx_next   = idx;
    frame_next = frame_cnt;
    phase_next = phase;
    if (pres_last) begin
      pres_next = '0;
      idx_next  = idx_last ? '0 : idx + 1'b1;
      if (idx_last) begin
        if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
          frame_next = '0;
          phase_next = ~phase;
        end else begin
          frame_next = frame_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!rst_n) begin
      pres      <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      pres      <= pres_next;
      idx       <= idx_next;
      frame_cnt <= frame_next;
      phase     <= phase_next;
    end
  end

  // ---------------------------------------------------------------- double buffer
  assign load_val = '{data: data, dp: dp, blank: blank_mask, blink: blink_mask, lz: lz_blank};

  always_ff @(posedge clk) begin
    // NOTE: pending/shadow are ordinary flops, not a RAM, so they are cleared here;
    // this is also what discards a load still waiting for its frame boundary.
    if (!rst_n) begin
      pending  <= '0;
      shadow   <= '0;
      pend_v   <= 1'b0;
      upd_done <= 1'b0;
    end else begin
      upd_done <= fb && (load || pend_v);
      if (fb && load) begin
        shadow <= load_val;
        pend_v <= 1'b0;
      end else if (fb && pend_v) begin
        shadow <= pending;
        pend_v <= 1'b0;
      end else if (load) begin
        pending <= load_val;
        pend_v  <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- digit selection
  logic [N_DIGITS-1:0] lz_dark, dark_vec;
  logic                upper_zero;

  // Scan from the most significant digit down: a digit is a leading zero while
  // it and everything above it are zero.
  always_comb begin
    upper_zero = 1'b1;
    lz_dark    = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (shadow.data[4*k +: 4] == 4'h0);
      lz_dark[k] = shadow.lz && (k != 0) && upper_zero;
    end
  end

  assign dark_vec = shadow.blank | (shadow.blink & {N_DIGITS{phase}}) | lz_dark;

  logic                in_guard, slot_dark;
  logic [3:0]          cur_nibble;
  logic [7:0]          seg_hi;
  logic [N_DIGITS-1:0] an_hi;

  assign in_guard   = int'(pres) < GUARD;
  assign slot_dark  = in_guard || dark_vec[idx];
  assign cur_nibble = shadow.data[{idx, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble (cur_nibble),
    .dp     (shadow.dp[idx]),
    .dark   (slot_dark),
    .seg    (seg_hi)
  );

  always_comb begin
    an_hi = '0;
    if (!slot_dark) an_hi[idx] = 1'b1;
  end

  // ---------------------------------------------------------------- pin registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      AN  <= (ACTIVE_LOW != 0) ? '1 : '0;
      SEG <= (ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
    end else begin
      AN  <= (ACTIVE_LOW != 0) ? ~an_hi : an_hi;
      SEG <= (ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: a cycle-count based display model is
// compared against AN/SEG/upd_done every cycle, plus literal spot checks.
module tb_seg7_scan_ctrl;

  localparam int N     = 8;
  localparam int DIV   = 4;
  localparam int GUARD = 1;
  localparam int BF    = 2;
  localparam int FRAME = N * DIV;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  data;
  logic [7:0]   dp, blank_mask, blink_mask;
  logic         lz_blank, load;
  logic         upd_done;
  logic [7:0]   an, seg;

  seg7_scan_ctrl #(
    .N_DIGITS(N), .DIV(DIV), .GUARD(GUARD), .BLINK_FRAMES(BF), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .dp(dp), .blank_mask(blank_mask),
    .blink_mask(blink_mask), .lz_blank(lz_blank), .load(load),
    .upd_done(upd_done), .AN(an), .SEG(seg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (time %0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic [7:0]  blink;
    logic        lz;
  } disp_t;

  disp_t      m_shadow, m_pending;
  bit         m_pend_v;
  int         m_t;        // cycles since reset release = scan position of the DUT
  bit         m_valid = 1'b0;
  logic [7:0] exp_an, exp_seg;
  logic       exp_upd;

  // Pin values for scan position t, derived from the cycle count alone.
  function automatic void model_out(input int t, input disp_t s,
                                    output logic [7:0] o_an, output logic [7:0] o_seg);
    int  k, p, msd;
    bit  phase, dark;
    k     = (t / DIV) % N;
    p     = t % DIV;
    phase = (((t / FRAME) / BF) % 2) == 1;
    msd   = 0;
    for (int i = 0; i < N; i++)
      if (s.data[4*i +: 4] != 4'h0) msd = i;
    dark = s.blank[k] || (s.blink[k] && phase) || (s.lz && k > msd);
    if (p < GUARD || dark) begin
      o_an  = 8'h00;
      o_seg = 8'h00;
    end else begin
      o_an  = 8'(1 << k);
      o_seg = {s.dp[k], SEG_TAB[s.data[4*k +: 4]]};
    end
    o_an  = ~o_an;
    o_seg = ~o_seg;
  endfunction

  always @(posedge clk) begin
    disp_t cur;
    bit    fb;
    if (!rst_n) begin
      m_t       = 0;
      m_shadow  = '0;
      m_pending = '0;
      m_pend_v  = 1'b0;
      exp_an    = 8'hFF;
      exp_seg   = 8'hFF;
      exp_upd   = 1'b0;
      m_valid   = 1'b1;
    end else if (m_valid) begin
      cur = '{data: data, dp: dp, blank: blank_mask, blink: blink_mask, lz: lz_blank};
      model_out(m_t, m_shadow, exp_an, exp_seg);
      fb      = (m_t % FRAME) == FRAME - 1;
      exp_upd = fb && (load || m_pend_v);
      if (load) begin
        if (fb) m_shadow = cur;
        else    m_pending = cur;
        m_pend_v = !fb;
      end else if (fb && m_pend_v) begin
        m_shadow = m_pending;
        m_pend_v = 1'b0;
      end
      m_t++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("an", an, exp_an);
      check("seg", seg, exp_seg);
      check("upd_done", upd_done, exp_upd);
    end
  end

  // ---------------------------------------------------------------- helpers
  // Outputs visible at a negedge belong to scan position m_t-1.
  task automatic wait_shown(input int target);
    for (int i = 0; i < 2000 && (m_t - 1) != target; i++) @(negedge clk);
    if ((m_t - 1) != target) begin
      checks++; errors++;
      $display("FAIL timeout waiting for position %0d (at %0d)", target, m_t - 1);
    end
  endtask

  task automatic wait_slot(input int k, input int p);
    for (int i = 0; i < 2 * FRAME && ((m_t - 1) % FRAME) != k * DIV + p; i++) @(negedge clk);
    if (((m_t - 1) % FRAME) != k * DIV + p) begin
      checks++; errors++;
      $display("FAIL timeout waiting for slot %0d pres %0d", k, p);
    end
  endtask

  task automatic count_upd(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (upd_done === 1'b1) n++;
    end
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] bl,
                         input logic [7:0] bk, input logic lz);
    data = d; dp = p; blank_mask = bl; blink_mask = bk; lz_blank = lz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic spot(input string name, input logic [7:0] a, input logic [7:0] s);
    check({name, "_an"}, an, a);
    check({name, "_seg"}, seg, s);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int n;
    rst_n = 1'b0; load = 1'b0; data = '0; dp = '0;
    blank_mask = '0; blink_mask = '0; lz_blank = 1'b0;

    // Reset state and idle display of zeros.
    repeat (2) @(negedge clk);
    spot("reset", 8'hFF, 8'hFF);
    check("reset_upd", upd_done, 1'b0);
    rst_n = 1'b1;
    wait_shown(1);  spot("idle_d0", 8'hFE, 8'hC0);
    wait_shown(4);  spot("idle_guard", 8'hFF, 8'hFF);
    wait_shown(5);  spot("idle_d1", 8'hFD, 8'hC0);
    wait_shown(2 * FRAME - 1);

    // Leading-zero suppression with a decimal point.
    wait_slot(2, 1);
    do_load(32'h0000_00A5, 8'h01, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 2 * FRAME && upd_done !== 1'b1; i++) @(negedge clk);
    check("upd_after_fb", 32'((m_t - 1) % FRAME), 32'(FRAME - 1));
    wait_slot(0, 1); spot("lz_d0", 8'hFE, 8'h12);
    wait_slot(1, 1); spot("lz_d1", 8'hFD, 8'h88);
    wait_slot(2, 1); spot("lz_d2", 8'hFF, 8'hFF);
    wait_slot(7, 2); spot("lz_d7", 8'hFF, 8'hFF);

    // Two loads in one frame: the later one wins, a single update pulse.
    wait_slot(1, 1);
    do_load(32'h1234_5678, 8'h00, 8'h00, 8'h00, 1'b0);
    do_load(32'h8765_4321, 8'h00, 8'h00, 8'h00, 1'b0);
    count_upd(2 * FRAME, n);
    check("double_load_upd_count", n, 1);
    wait_slot(0, 1); spot("dbl_d0", 8'hFE, 8'hF9);
    wait_slot(7, 1); spot("dbl_d7", 8'h7F, 8'h80);

    // Load landing exactly on the frame boundary.
    wait_slot(7, 2);
    do_load(32'h0000_00C3, 8'h00, 8'h00, 8'h00, 1'b0);
    check("fb_load_upd", upd_done, 1'b1);
    @(negedge clk);
    @(negedge clk);
    spot("fb_load_d0", 8'hFE, 8'hB0);
    wait_slot(1, 1); spot("fb_load_d1", 8'hFD, 8'hC6);

    // Reset mid-slot with a load still pending.
    wait_slot(3, 2);
    data = 32'hFFFF_FFFF; dp = 8'hFF; load = 1'b1;
    @(negedge clk);
    load = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    spot("mid_reset", 8'hFF, 8'hFF);
    check("mid_reset_upd", upd_done, 1'b0);
    count_upd(70, n);
    check("no_upd_after_reset", n, 0);

    // Blink with BLINK_FRAMES = 2, frames counted from a fresh reset.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_load(32'h0000_0000, 8'h00, 8'h00, 8'h01, 1'b0);
    wait_shown(1 * FRAME + 1); spot("blink_f1_d0", 8'hFE, 8'hC0);
    wait_shown(2 * FRAME + 1); spot("blink_f2_d0", 8'hFF, 8'hFF);
    wait_shown(2 * FRAME + 5); spot("blink_f2_d1", 8'hFD, 8'hC0);
    wait_shown(3 * FRAME + 1); spot("blink_f3_d0", 8'hFF, 8'hFF);
    wait_shown(4 * FRAME + 1); spot("blink_f4_d0", 8'hFE, 8'hC0);
    wait_shown(5 * FRAME + 1); spot("blink_f5_d0", 8'hFE, 8'hC0);
    wait_shown(6 * FRAME + 1); spot("blink_f6_d0", 8'hFF, 8'hFF);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
